// File: rtl/weight_buffer_pkg.sv
// Shared types and helpers for the per-layer weight buffer and its weight_updater users.
// Latency: none (types and constant functions only).
// Backpressure: n/a.
package weight_buffer_pkg;

   // Buffer FSM encoding: IDLE accepts load/read, SEND presents a matrix, WAIT awaits writeback
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } wb_state_t;

   // Flattened width of one NEURON_NUM x NEURON_NUM matrix of signed cells
   function automatic int unsigned matrix_width(input int unsigned neuron_num,
                                                input int unsigned cell_width);
      return neuron_num * neuron_num * cell_width;
   endfunction

endpackage

// File: rtl/weight_buffer_layer_mem.sv
// Layer-indexed register array: one write port, one combinational read port, cleared on reset.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; writes are accepted every cycle i_we is high.
module weight_buffer_layer_mem #(
   parameter int DEPTH  = 3,
   parameter int ADDR_W = 2,
   parameter int DATA_W = 400
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] w_rdata;

   // Storage: clear every slot on reset, otherwise write the addressed slot
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_waddr == ADDR_W'(i)) begin
               r_mem[i] <= i_wdata;
            end
         end
      end
   end

   // Read mux: addresses beyond DEPTH return zero instead of indexing off the array
   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_raddr == ADDR_W'(i)) begin
            w_rdata = r_mem[i];
         end
      end
   end

   assign o_rdata = w_rdata;

endmodule

// File: rtl/weight_buffer.sv
// Per-layer weight store around weight_updater: serves one layer matrix, locks it, writes result back.
// Latency: w_valid 1 cycle after read handshake; writeback visible to a read accepted the next cycle.
// Backpressure: one outstanding update; load/read stall outside IDLE, writeback only taken in WAIT.
// Optional: define WEIGHT_BUFFER_WB_CHECK_EN to add i_wb_layer / o_wb_mismatch writeback layer check.
module weight_buffer
   import weight_buffer_pkg::*;
#(
   parameter int NEURON_NUM        = 5,
   parameter int WEIGHT_CELL_WIDTH = 16,
   parameter int LAYER_NUM         = 3,
   parameter int LAYER_ADDR_WIDTH  = 2,
   localparam int unsigned MATRIX_W = matrix_width(NEURON_NUM, WEIGHT_CELL_WIDTH)
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [LAYER_ADDR_WIDTH-1:0] i_load_layer,
   input  logic [MATRIX_W-1:0]         i_load_data,
   input  logic                        i_load_valid,
   output logic                        o_load_ready,
   input  logic [LAYER_ADDR_WIDTH-1:0] i_rd_layer,
   input  logic                        i_rd_valid,
   output logic                        o_rd_ready,
   output logic [MATRIX_W-1:0]         o_w,
   output logic                        o_w_valid,
   input  logic                        i_w_ready,
   input  logic [MATRIX_W-1:0]         i_wb_data,
   input  logic                        i_wb_valid,
   output logic                        o_wb_ready,
`ifdef WEIGHT_BUFFER_WB_CHECK_EN
   input  logic [LAYER_ADDR_WIDTH-1:0] i_wb_layer,
   output logic                        o_wb_mismatch,
`endif
   output logic                        o_addr_error,
   output logic                        o_busy
);

   // One extra bit so LAYER_NUM itself is representable for the range check
   localparam logic [LAYER_ADDR_WIDTH:0] LP_LAYER_LIMIT = (LAYER_ADDR_WIDTH+1)'(LAYER_NUM);

   wb_state_t                   r_state;
   logic [LAYER_ADDR_WIDTH-1:0] r_layer;
   logic [MATRIX_W-1:0]         r_w;
   logic                        r_w_valid;
   logic                        r_addr_error;
   logic                        r_busy;
`ifdef WEIGHT_BUFFER_WB_CHECK_EN
   logic                        r_wb_mismatch;
`endif

   logic                        w_idle;
   logic                        w_load_fire;
   logic                        w_rd_fire;
   logic                        w_wb_fire;
   logic                        w_load_in_range;
   logic                        w_rd_in_range;
   logic                        w_wb_layer_ok;
   logic                        w_mem_we;
   logic [LAYER_ADDR_WIDTH-1:0] w_mem_waddr;
   logic [MATRIX_W-1:0]         w_mem_wdata;
   logic [MATRIX_W-1:0]         w_mem_rdata;

   assign w_idle = (r_state == ST_IDLE);

   // Ready signals come from state only, except rd_ready which yields to a pending load
   assign o_load_ready = w_idle;
   assign o_rd_ready   = w_idle && !i_load_valid;
   assign o_wb_ready   = (r_state == ST_WAIT);

   assign w_load_fire = i_load_valid && o_load_ready;
   assign w_rd_fire   = i_rd_valid && o_rd_ready;
   assign w_wb_fire   = i_wb_valid && o_wb_ready;

   assign w_load_in_range = ({1'b0, i_load_layer} < LP_LAYER_LIMIT);
   assign w_rd_in_range   = ({1'b0, i_rd_layer} < LP_LAYER_LIMIT);

`ifdef WEIGHT_BUFFER_WB_CHECK_EN
   assign w_wb_layer_ok = (i_wb_layer == r_layer);
`else
   assign w_wb_layer_ok = 1'b1;
`endif

   // Load (IDLE) and writeback (WAIT) are mutually exclusive, so one write port suffices
   assign w_mem_we    = (w_load_fire && w_load_in_range) || (w_wb_fire && w_wb_layer_ok);
   assign w_mem_waddr = w_wb_fire ? r_layer : i_load_layer;
   assign w_mem_wdata = w_wb_fire ? i_wb_data : i_load_data;

   weight_buffer_layer_mem #(
      .DEPTH  (LAYER_NUM),
      .ADDR_W (LAYER_ADDR_WIDTH),
      .DATA_W (int'(MATRIX_W))
   ) u_layer_mem (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (w_mem_we),
      .i_waddr (w_mem_waddr),
      .i_wdata (w_mem_wdata),
      .i_raddr (i_rd_layer),
      .o_rdata (w_mem_rdata)
   );

   // Transaction FSM with all outputs registered; error flags are single-cycle pulses
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state      <= ST_IDLE;
         r_layer      <= '0;
         r_w          <= '0;
         r_w_valid    <= 1'b0;
         r_addr_error <= 1'b0;
         r_busy       <= 1'b0;
`ifdef WEIGHT_BUFFER_WB_CHECK_EN
         r_wb_mismatch <= 1'b0;
`endif
      end else begin
         r_addr_error <= 1'b0;
`ifdef WEIGHT_BUFFER_WB_CHECK_EN
         r_wb_mismatch <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_load_fire) begin
                  // Out-of-range load is consumed without touching memory
                  if (!w_load_in_range) begin
                     r_addr_error <= 1'b1;
                  end
               end else if (w_rd_fire) begin
                  if (w_rd_in_range) begin
                     r_layer   <= i_rd_layer;
                     r_w       <= w_mem_rdata;
                     r_w_valid <= 1'b1;
                     r_busy    <= 1'b1;
                     r_state   <= ST_SEND;
                  end else begin
                     r_addr_error <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               // Matrix held stable until the updater takes it
               if (i_w_ready) begin
                  r_w_valid <= 1'b0;
                  r_state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_wb_valid) begin
`ifdef WEIGHT_BUFFER_WB_CHECK_EN
                  r_wb_mismatch <= !w_wb_layer_ok;
`endif
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_w_valid <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_w          = r_w;
   assign o_w_valid    = r_w_valid;
   assign o_addr_error = r_addr_error;
   assign o_busy       = r_busy;
`ifdef WEIGHT_BUFFER_WB_CHECK_EN
   assign o_wb_mismatch = r_wb_mismatch;
`endif

endmodule
